// File: rtl/fft_sdf_stage.sv
// fft_sdf_stage: one radix-2 single-path delay-feedback (SDF) FFT stage.
// Each frame is 2*DELAY accepted samples. The first DELAY samples of a
// frame fill the feedback delay line and push out the previous frame's
// stored differences, which the downstream twiddle multiplier rotates.
// The last DELAY samples are butterflied against the delay-line head.
// The half-sum is emitted. The half-difference is stored for the next frame.
// Optional feature: define FFT_SDF_ROUND_EN to round the halved sums and
// differences, with positive saturation. The default build truncates.
//
// Handshake: there is no backpressure. in_valid qualifies in_data on the
// cycle it is high. All state advances only on accepted samples. out_valid
// qualifies out_data/tw_en/tw_idx exactly one cycle after acceptance.
module fft_sdf_stage #(
  parameter int DELAY = 4,
  parameter int TW_W  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [23:0]     in_data,
  output logic            out_valid,
  output logic [23:0]     out_data,
  output logic            tw_en,
  output logic [TW_W-1:0] tw_idx
);

  localparam int CW = TW_W + 1;

  // Frame position. The top bit set means butterfly phase.
  logic [CW-1:0]   cnt;
  logic            primed;
  logic [23:0]     mem [DELAY];

  logic [TW_W-1:0] addr;
  logic            fill;
  logic [23:0]     head;

  assign addr = cnt[TW_W-1:0];
  assign fill = ~cnt[TW_W];
  assign head = mem[addr];

  // 13-bit full-precision sum and difference per component.
  logic signed [12:0] sum_re, sum_im, dif_re, dif_im;
  logic [11:0]        sum_re_h, sum_im_h, dif_re_h, dif_im_h;

  assign sum_re = {head[23], head[23:12]} + {in_data[23], in_data[23:12]};
  assign sum_im = {head[11], head[11:0]}  + {in_data[11], in_data[11:0]};
  assign dif_re = {head[23], head[23:12]} - {in_data[23], in_data[23:12]};
  assign dif_im = {head[11], head[11:0]}  - {in_data[11], in_data[11:0]};

`ifdef FFT_SDF_ROUND_EN
  // (s+1)>>>1 equals (s>>>1) plus the dropped LSB. Only s>>>1 == +2047
  // with the LSB set can overflow, and that case saturates to +2047.
  assign sum_re_h = (sum_re[12:1] == 12'h7FF && sum_re[0]) ? 12'h7FF
                  : sum_re[12:1] + {11'd0, sum_re[0]};
  assign sum_im_h = (sum_im[12:1] == 12'h7FF && sum_im[0]) ? 12'h7FF
                  : sum_im[12:1] + {11'd0, sum_im[0]};
  assign dif_re_h = (dif_re[12:1] == 12'h7FF && dif_re[0]) ? 12'h7FF
                  : dif_re[12:1] + {11'd0, dif_re[0]};
  assign dif_im_h = (dif_im[12:1] == 12'h7FF && dif_im[0]) ? 12'h7FF
                  : dif_im[12:1] + {11'd0, dif_im[0]};
`else
  // Plain arithmetic shift. A 13-bit value halved always fits in 12 bits.
  assign sum_re_h = sum_re[12:1];
  assign sum_im_h = sum_im[12:1];
  assign dif_re_h = dif_re[12:1];
  assign dif_im_h = dif_im[12:1];
  logic unused_lsbs;
  assign unused_lsbs = ^{sum_re[0], sum_im[0], dif_re[0], dif_im[0]};
`endif

  // Delay line: the slot for this frame position receives the raw sample
  // in the fill phase and the half-difference in the butterfly phase.
  // This line is never reset.
  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      mem[addr] <= fill ? in_data : {dif_re_h, dif_im_h};
    end
  end

  // Frame counter, primed flag and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      primed    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      tw_en     <= 1'b0;
      tw_idx    <= '0;
    end else if (in_valid) begin
      cnt <= cnt + 1'b1;
      if (&cnt) begin
        primed <= 1'b1;
      end
      if (fill) begin
        out_valid <= primed;
        out_data  <= head;
        tw_en     <= 1'b1;
        tw_idx    <= addr;
      end else begin
        out_valid <= 1'b1;
        out_data  <= {sum_re_h, sum_im_h};
        tw_en     <= 1'b0;
        tw_idx    <= '0;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_sdf_stage.sv
// tb_fft_sdf_stage: directed and random stimulus for fft_sdf_stage (DELAY=4).
// Reference model: within a frame, sample n (n < D) is kept raw. Sample
// n+D produces the half-sum with raw[n]. The half-difference is what
// frame position n emits in the following frame.
module tb_fft_sdf_stage;
  localparam int D  = 4;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [23:0]   in_data = '0;
  logic          out_valid;
  logic [23:0]   out_data;
  logic          tw_en;
  logic [TW-1:0] tw_idx;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_cnt = 0;
  bit m_primed = 0;
  int raw_re [D];
  int raw_im [D];
  int pend_re [D];
  int pend_im [D];

  // Last observed real/imag part of out_data, as signed values.
  int last_re, last_im;

  fft_sdf_stage #(.DELAY(D), .TW_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .tw_en(tw_en), .tw_idx(tw_idx)
  );

  // Clock.
  always #5 clk = ~clk;

  function automatic int half(int x);
`ifdef FFT_SDF_ROUND_EN
    int y;
    y = (x + 1) >>> 1;
    if (y > 2047) y = 2047;
    return y;
`else
    return x >>> 1;
`endif
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 24'h123456;
    @(posedge clk); #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_tw_en", int'(tw_en), 0);
    chk("rst_tw_idx", int'(tw_idx), 0);
    rst = 1'b0;
    in_valid = 1'b0;
    m_cnt = 0;
    m_primed = 0;
  endtask

  // One cycle: drive, predict, clock, compare.
  task automatic step(input bit v, input int re, input int im);
    bit e_valid;
    int e_re, e_im, e_tw, e_idx, n;
    e_valid = 0; e_re = 0; e_im = 0; e_tw = 0; e_idx = 0;
    in_valid = v;
    in_data = {12'(re), 12'(im)};
    if (v) begin
      n = m_cnt % D;
      if (m_cnt < D) begin
        e_valid = m_primed;
        e_re = pend_re[n]; e_im = pend_im[n];
        e_tw = 1; e_idx = n;
        raw_re[n] = re; raw_im[n] = im;
      end else begin
        e_valid = 1;
        e_re = half(raw_re[n] + re); e_im = half(raw_im[n] + im);
        pend_re[n] = half(raw_re[n] - re);
        pend_im[n] = half(raw_im[n] - im);
      end
      m_cnt = (m_cnt + 1) % (2 * D);
      if (m_cnt == 0) m_primed = 1;
    end
    @(posedge clk); #1;
    last_re = int'($signed(out_data[23:12]));
    last_im = int'($signed(out_data[11:0]));
    chk("out_valid", int'(out_valid), int'(e_valid));
    if (e_valid) begin
      chk("out_re", last_re, e_re);
      chk("out_im", last_im, e_im);
      chk("tw_en", int'(tw_en), e_tw);
      chk("tw_idx", int'(tw_idx), e_idx);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset: outputs cleared even with in_valid high.
    @(posedge clk); #1;
    do_reset();

    // Ramp frame: fill outputs are invalid, then the sums 300..600.
    for (int i = 0; i < 2 * D; i++) begin
      step(1, 100 * (i + 1), 0);
      if (i >= D) begin
        chk("ramp_sum", last_re, 300 + 100 * (i - D));
        chk("ramp_tw_en", int'(tw_en), 0);
      end
    end
    // Zero frame: the stored differences come out, -200 four times.
    for (int i = 0; i < 2 * D; i++) begin
      step(1, 0, 0);
      if (i < D) begin
        chk("diff_re", last_re, -200);
        chk("diff_tw_idx", int'(tw_idx), i);
        chk("diff_tw_en", int'(tw_en), 1);
      end
    end

    // Extremes and the (1,2) rounding pair.
    step(1, 2047, 2047);   step(1, -2048, -2048);
    step(1, 2047, -2048);  step(1, 1, 0);
    step(1, 2047, 2047);   chk("max_sum", last_re, 2047);
    step(1, -2048, -2048); chk("min_sum", last_re, -2048);
    step(1, -2048, 2047);
    step(1, 2, 0);
`ifdef FFT_SDF_ROUND_EN
    chk("pair_sum", last_re, 2);
`else
    chk("pair_sum", last_re, 1);
`endif
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    step(1, 0, 0);
`ifdef FFT_SDF_ROUND_EN
    chk("pair_diff", last_re, 0);
`else
    chk("pair_diff", last_re, -1);
`endif
    for (int i = 0; i < D; i++) step(1, 0, 0);

    // Gaps inside a frame: no output follows an idle cycle.
    for (int i = 0; i < 2 * D; i++) begin
      step(1, 37 * i - 100, 11 * i);
      step(0, 999, 999);
    end

    // Mid-frame reset at cnt=5, then the ramp frame again.
    for (int i = 0; i < 5; i++) step(1, 500 - 77 * i, 3 * i);
    do_reset();
    for (int i = 0; i < 2 * D; i++) begin
      step(1, 100 * (i + 1), 0);
      if (i >= D) chk("rst_ramp_sum", last_re, 300 + 100 * (i - D));
    end

    // Random traffic with random idle cycles.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0,
           int'($urandom_range(0, 4095)) - 2048,
           int'($urandom_range(0, 4095)) - 2048);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_sdf_stage.md
FFT_SDF_STAGE -- requirements
Module: fft_sdf_stage

Interface
REQ-001 SHALL have parameter DELAY, default 4, giving the feedback delay depth in samples (power of 2, 2..256).
REQ-002 SHALL have parameter TW_W, default 2, giving the twiddle index width as log2(DELAY).
REQ-003 SHALL have port clk, input, 1 bit, single rising-edge clock for all state.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit, qualifying in_data for the current cycle.
REQ-006 SHALL have port in_data, input, 24 bits, packed complex sample: [23:12] signed real, [11:0] signed imaginary.
REQ-007 SHALL have port out_valid, output, 1 bit, qualifying out_data, tw_en and tw_idx.
REQ-008 SHALL have port out_data, output, 24 bits, butterfly result in the same packing as in_data.
REQ-009 SHALL have port tw_en, output, 1 bit, high when out_data is a difference term that the downstream twiddle multiplier must rotate.
REQ-010 SHALL have port tw_idx, output, TW_W bits, twiddle ROM index for out_data; 0 when tw_en=0.

Function
REQ-011 SHALL keep a sample counter cnt, modulo 2*DELAY, that advances only on cycles with in_valid=1; cycles with in_valid=0 SHALL leave all state unchanged and drive out_valid=0 on the next cycle.
REQ-012 SHALL keep a DELAY-entry delay line (shift register or circular buffer) of 24-bit entries, advanced only when in_valid=1; head = entry written DELAY accepted samples earlier.
REQ-013 Fill phase (cnt<DELAY): in_data SHALL be written to the delay line; the output SHALL be the head entry (the previous frame's stored difference), with tw_en=1 and tw_idx=cnt[TW_W-1:0].
REQ-014 Butterfly phase (cnt>=DELAY), with a=head and b=in_data: out_data SHALL be (a+b)>>>1 per component, with tw_en=0 and tw_idx=0; (a-b)>>>1 per component SHALL be written to the delay line.
REQ-015 Arithmetic SHALL be 13-bit signed per component, then an arithmetic right shift by 1 to 12 bits; the result SHALL never overflow or wrap.
REQ-016 Outputs SHALL be registered with latency exactly 1 clk: the input accepted at edge k produces out_valid=1 and its result after edge k+1.
REQ-017 A primed flag SHALL be set when cnt wraps from 2*DELAY-1 to 0 for the first time; while primed=0, fill-phase outputs SHALL carry out_valid=0, because the delay line holds no valid data yet.
REQ-018 Butterfly-phase outputs SHALL assert out_valid regardless of primed.
REQ-019 cnt wrap from 2*DELAY-1 to 0 SHALL occur without a bubble; a frame SHALL be exactly 2*DELAY accepted samples.

Reset
REQ-020 On rst=1 at a clk edge: cnt=0, primed=0, out_valid=0, out_data=0, tw_en=0, tw_idx=0; delay-line contents are don't-care and SHALL NOT be reset.
REQ-021 rst SHALL override in_valid in the same cycle; a reset mid-frame SHALL discard the partial frame, and the next accepted sample SHALL be frame sample 0 with primed=0.

Configuration
REQ-022 With macro FFT_SDF_ROUND_EN defined, each 13-bit sum or difference SHALL have 1 added before the shift, saturated to +2047 on positive overflow.
REQ-023 Without FFT_SDF_ROUND_EN, the block SHALL truncate with a plain arithmetic shift and use no saturation logic.

Verification (DELAY=4, imaginary=0 unless stated)
REQ-024 After rst, send continuous real inputs 100,200,...,800 -> first four cycles out_valid=0; then out_data real 300,400,500,600 with tw_en=0, one cycle after samples 4..7.
REQ-025 Follow REQ-024 with a second frame of zeros -> the first four outputs are real -200 ×4, with tw_en=1 and tw_idx=0,1,2,3.
REQ-026 Inputs 2047 and 2047 paired (cnt 0 and 4) -> sum 2047; inputs -2048 and -2048 -> sum -2048; no wrap in either mode.
REQ-027 Pair (1,2) real: without FFT_SDF_ROUND_EN -> sum 1, diff -1; with FFT_SDF_ROUND_EN -> sum 2, diff 0.
REQ-028 Toggle in_valid 1,0,1,0 within a frame -> results are identical to the gap-free run, with out_valid=0 on the cycles following gaps.
REQ-029 Assert rst at cnt=5 mid-frame, then resend the REQ-024 frame -> output matches REQ-024 exactly, with no stale sums emitted.
